mem_arbiter: RTL and testbench

Two-to-one arbiter between the instruction cache and data cache miss/write-through ports and the single external memory port. It grants one requester at a time and forwards its word-granular request combinationally. It tracks the single outstanding read and routes the returned data and valid back to its owner only. It sits directly downstream of both cache instances, and its memory side connects to the memory model.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: 2:1 icache/dcache arbiter onto one memory port,
// tracking the single outstanding read and routing its return.
module mem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_ic_mem_ready,
  input  logic [31:0] i_ic_mem_addr,
  input  logic        i_ic_mem_ren,
  input  logic        i_ic_mem_wen,
  input  logic [31:0] i_ic_mem_wdata,
  output logic [31:0] o_ic_mem_rdata,
  output logic        o_ic_mem_valid,
  output logic        o_dc_mem_ready,
  input  logic [31:0] i_dc_mem_addr,
  input  logic        i_dc_mem_ren,
  input  logic        i_dc_mem_wen,
  input  logic [31:0] i_dc_mem_wdata,
  output logic [31:0] o_dc_mem_rdata,
  output logic        o_dc_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_ren,
  output logic        o_mem_wen,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_valid
);

  typedef enum logic [1:0] {
    IDLE,
    RD_IC,
    RD_DC
  } state_t;

  state_t state;
  logic   last_dc;

  logic ic_act;
  logic dc_act;
  logic any_act;
  logic idle;
  logic dc_win;
  logic ic_win;
  logic fire;
  logic win_ren;

  assign ic_act  = i_ic_mem_ren | i_ic_mem_wen;
  assign dc_act  = i_dc_mem_ren | i_dc_mem_wen;
  assign any_act = ic_act | dc_act;
  assign idle    = (state == IDLE);

  // On a tie the dcache wins unless round-robin says it went last.
  assign dc_win = dc_act &
                  (~ic_act | ~RR_EN | ~last_dc);
  assign ic_win = ic_act & ~dc_win;

  assign fire    = idle & i_mem_ready & any_act;
  assign win_ren = dc_win ? i_dc_mem_ren
                          : i_ic_mem_ren;

  assign o_ic_mem_ready = idle & i_mem_ready &
                          (ic_win | ~any_act);
  assign o_dc_mem_ready = idle & i_mem_ready &
                          (dc_win | ~any_act);

  assign o_ic_mem_rdata = i_mem_rdata;
  assign o_dc_mem_rdata = i_mem_rdata;
  assign o_ic_mem_valid = i_mem_valid &
                          (state == RD_IC);
  assign o_dc_mem_valid = i_mem_valid &
                          (state == RD_DC);

  // Strobes only show when the memory can take them.
  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_ren   = 1'b0;
    o_mem_wen   = 1'b0;
    if (idle && dc_win) begin
      o_mem_addr  = i_dc_mem_addr;
      o_mem_wdata = i_dc_mem_wdata;
      o_mem_ren   = i_dc_mem_ren & i_mem_ready;
      o_mem_wen   = i_dc_mem_wen & i_mem_ready;
    end else if (idle && ic_win) begin
      o_mem_addr  = i_ic_mem_addr;
      o_mem_wdata = i_ic_mem_wdata;
      o_mem_ren   = i_ic_mem_ren & i_mem_ready;
      o_mem_wen   = i_ic_mem_wen & i_mem_ready;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      last_dc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (fire) begin
            last_dc <= dc_win;
            if (win_ren)
              state <= dc_win ? RD_DC : RD_IC;
          end
        end
        RD_IC, RD_DC: begin
          if (i_mem_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed plus random checks of mem_arbiter,
// instance 0 round-robin, instance 1 fixed priority.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ic_ren[2], ic_wen[2];
  logic        dc_ren[2], dc_wen[2];
  logic        mready[2], mvalid[2];
  logic [31:0] ic_addr[2], ic_wdata[2];
  logic [31:0] dc_addr[2], dc_wdata[2];
  logic [31:0] mrdata[2];
  logic        ic_rdy[2], dc_rdy[2];
  logic        ic_v[2], dc_v[2];
  logic        m_ren[2], m_wen[2];
  logic [31:0] ic_rd[2], dc_rd[2];
  logic [31:0] m_addr[2], m_wdata[2];

  mem_arbiter #(.RR_EN(1'b1)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .o_ic_mem_ready(ic_rdy[0]),
    .i_ic_mem_addr(ic_addr[0]),
    .i_ic_mem_ren(ic_ren[0]),
    .i_ic_mem_wen(ic_wen[0]),
    .i_ic_mem_wdata(ic_wdata[0]),
    .o_ic_mem_rdata(ic_rd[0]),
    .o_ic_mem_valid(ic_v[0]),
    .o_dc_mem_ready(dc_rdy[0]),
    .i_dc_mem_addr(dc_addr[0]),
    .i_dc_mem_ren(dc_ren[0]),
    .i_dc_mem_wen(dc_wen[0]),
    .i_dc_mem_wdata(dc_wdata[0]),
    .o_dc_mem_rdata(dc_rd[0]),
    .o_dc_mem_valid(dc_v[0]),
    .i_mem_ready(mready[0]),
    .o_mem_addr(m_addr[0]),
    .o_mem_ren(m_ren[0]),
    .o_mem_wen(m_wen[0]),
    .o_mem_wdata(m_wdata[0]),
    .i_mem_rdata(mrdata[0]),
    .i_mem_valid(mvalid[0])
  );

  mem_arbiter #(.RR_EN(1'b0)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .o_ic_mem_ready(ic_rdy[1]),
    .i_ic_mem_addr(ic_addr[1]),
    .i_ic_mem_ren(ic_ren[1]),
    .i_ic_mem_wen(ic_wen[1]),
    .i_ic_mem_wdata(ic_wdata[1]),
    .o_ic_mem_rdata(ic_rd[1]),
    .o_ic_mem_valid(ic_v[1]),
    .o_dc_mem_ready(dc_rdy[1]),
    .i_dc_mem_addr(dc_addr[1]),
    .i_dc_mem_ren(dc_ren[1]),
    .i_dc_mem_wen(dc_wen[1]),
    .i_dc_mem_wdata(dc_wdata[1]),
    .o_dc_mem_rdata(dc_rd[1]),
    .o_dc_mem_valid(dc_v[1]),
    .i_mem_ready(mready[1]),
    .o_mem_addr(m_addr[1]),
    .o_mem_ren(m_ren[1]),
    .o_mem_wen(m_wen[1]),
    .o_mem_wdata(m_wdata[1]),
    .i_mem_rdata(mrdata[1]),
    .i_mem_valid(mvalid[1])
  );

  // Reference: who owns the outstanding read (0 none,
  // 1 icache, 2 dcache) and whether dcache went last.
  int owner[2];
  bit last_dc[2];
  int lat[2];
  bit fired_ic[2], fired_dc[2], fired_rd[2];
  int errors = 0;
  int checks = 0;

  task automatic chk(string tag, int k,
                     logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%h expected=%h",
             tag, k, obs, exp);
    end
  endtask

  task automatic step();
    int win;
    bit ica, dca;
    logic [31:0] e_addr, e_wd;
    bit e_ren, e_wen;
    #1;
    for (int k = 0; k < 2; k++) begin
      ica = ic_ren[k] | ic_wen[k];
      dca = dc_ren[k] | dc_wen[k];
      win = 0;
      if (owner[k] == 0) begin
        if (ica && dca)
          win = (k == 0 && last_dc[k]) ? 1 : 2;
        else if (ica) win = 1;
        else if (dca) win = 2;
      end
      e_addr = 0; e_wd = 0; e_ren = 0; e_wen = 0;
      if (win == 1) begin
        e_addr = ic_addr[k]; e_wd = ic_wdata[k];
        e_ren = ic_ren[k] & mready[k];
        e_wen = ic_wen[k] & mready[k];
      end else if (win == 2) begin
        e_addr = dc_addr[k]; e_wd = dc_wdata[k];
        e_ren = dc_ren[k] & mready[k];
        e_wen = dc_wen[k] & mready[k];
      end
      chk("ic_ready", k, 32'(ic_rdy[k]),
          32'(owner[k] == 0 && mready[k] && win != 2));
      chk("dc_ready", k, 32'(dc_rdy[k]),
          32'(owner[k] == 0 && mready[k] && win != 1));
      chk("mem_ren", k, 32'(m_ren[k]), 32'(e_ren));
      chk("mem_wen", k, 32'(m_wen[k]), 32'(e_wen));
      chk("mem_addr", k, m_addr[k], e_addr);
      chk("mem_wdata", k, m_wdata[k], e_wd);
      chk("ic_valid", k, 32'(ic_v[k]),
          32'(mvalid[k] && owner[k] == 1));
      chk("dc_valid", k, 32'(dc_v[k]),
          32'(mvalid[k] && owner[k] == 2));
      chk("ic_rdata", k, ic_rd[k], mrdata[k]);
      chk("dc_rdata", k, dc_rd[k], mrdata[k]);
      fired_ic[k] = (win == 1) && mready[k];
      fired_dc[k] = (win == 2) && mready[k];
      fired_rd[k] = (fired_ic[k] && ic_ren[k]) ||
                    (fired_dc[k] && dc_ren[k]);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner[k] = 0;
        last_dc[k] = 0;
      end else if (owner[k] != 0) begin
        if (mvalid[k]) owner[k] = 0;
      end else if (fired_ic[k] || fired_dc[k]) begin
        last_dc[k] = fired_dc[k];
        if (fired_rd[k]) owner[k] = fired_dc[k] ? 2 : 1;
      end
    end
    #1;
  endtask

  task automatic ic_req(bit r, bit w,
                        logic [31:0] a, logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      ic_ren[k] = r; ic_wen[k] = w;
      ic_addr[k] = a; ic_wdata[k] = d;
    end
  endtask

  task automatic dc_req(bit r, bit w,
                        logic [31:0] a, logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      dc_ren[k] = r; dc_wen[k] = w;
      dc_addr[k] = a; dc_wdata[k] = d;
    end
  endtask

  task automatic mem(bit rdy, bit v, logic [31:0] d);
    for (int k = 0; k < 2; k++) begin
      mready[k] = rdy; mvalid[k] = v; mrdata[k] = d;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      owner[k] = 0; last_dc[k] = 0; lat[k] = 0;
    end
    rst = 1'b1;
    ic_req(0, 0, 0, 0);
    dc_req(0, 0, 0, 0);
    mem(1, 0, 0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    chk("rst_ic_ready", 0, 32'(ic_rdy[0]), 1);
    chk("rst_dc_ready", 1, 32'(dc_rdy[1]), 1);
    step();

    // single icache read, data back on the third cycle
    ic_req(1, 0, 32'h100, 0);
    #1;
    chk("t1_addr", 0, m_addr[0], 32'h100);
    chk("t1_ren", 0, 32'(m_ren[0]), 1);
    step();
    ic_req(0, 0, 0, 0);
    chk("t1_wait_ic_rdy", 0, 32'(ic_rdy[0]), 0);
    chk("t1_wait_dc_rdy", 0, 32'(dc_rdy[0]), 0);
    step();
    step();
    mem(1, 1, 32'hDEADBEEF);
    #1;
    chk("t1_ic_valid", 0, 32'(ic_v[0]), 1);
    chk("t1_ic_rdata", 0, ic_rd[0], 32'hDEADBEEF);
    chk("t1_dc_valid", 0, 32'(dc_v[0]), 0);
    step();
    mem(1, 0, 0);
    step();

    // tie after reset: dcache first, then icache
    rst = 1'b1;
    step();
    rst = 1'b0;
    ic_req(1, 0, 32'h200, 0);
    dc_req(1, 0, 32'h300, 0);
    #1;
    chk("t2_first_rr", 0, m_addr[0], 32'h300);
    chk("t2_first_fp", 1, m_addr[1], 32'h300);
    step();
    dc_req(0, 0, 0, 0);
    step();
    mem(1, 1, 32'hA5A5A5A5);
    #1;
    chk("t2_dc_valid", 0, 32'(dc_v[0]), 1);
    step();
    mem(1, 0, 0);
    #1;
    chk("t2_ic_next", 0, m_addr[0], 32'h200);
    step();
    ic_req(0, 0, 0, 0);
    mem(1, 1, 32'h0000_1111);
    step();
    mem(1, 0, 0);
    ic_req(1, 0, 32'h204, 0);
    dc_req(1, 0, 32'h304, 0);
    #1;
    chk("t2_tie_again", 0, m_addr[0], 32'h304);
    step();
    dc_req(0, 0, 0, 0);
    mem(1, 1, 32'h2222);
    step();
    mem(1, 0, 0);
    step();
    ic_req(0, 0, 0, 0);
    mem(1, 1, 32'h3333);
    step();
    mem(1, 0, 0);

    // both continuously requesting
    ic_req(1, 0, 32'h500, 0);
    dc_req(1, 0, 32'h400, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t3_fp_dc_wins", 1, m_addr[1], 32'h400);
      step();
      mem(1, 1, 32'(i));
      step();
      mem(1, 0, 0);
    end
    dc_req(0, 0, 0, 0);
    #1;
    chk("t3_fp_ic_gets", 1, m_addr[1], 32'h500);
    step();
    ic_req(0, 0, 0, 0);
    mem(1, 1, 32'h4444);
    step();
    mem(1, 0, 0);

    // write then read back-to-back
    dc_req(0, 1, 32'h40, 32'h12345678);
    #1;
    chk("t4_wen", 0, 32'(m_wen[0]), 1);
    chk("t4_wdata", 0, m_wdata[0], 32'h12345678);
    step();
    dc_req(1, 0, 32'h40, 0);
    #1;
    chk("t4_ren", 0, 32'(m_ren[0]), 1);
    chk("t4_no_wr_valid", 0, 32'(dc_v[0]), 0);
    step();
    dc_req(0, 0, 0, 0);
    mem(1, 1, 32'h12345678);
    #1;
    chk("t4_rd_valid", 0, 32'(dc_v[0]), 1);
    step();
    mem(1, 0, 0);

    // memory stalls for four cycles
    dc_req(1, 0, 32'h80, 0);
    mem(0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t5_no_ren", 0, 32'(m_ren[0]), 0);
      chk("t5_dc_rdy", 0, 32'(dc_rdy[0]), 0);
      step();
    end
    mem(1, 0, 0);
    #1;
    chk("t5_fires", 0, 32'(m_ren[0]), 1);
    step();
    dc_req(0, 0, 0, 0);
    mem(1, 1, 32'h5555);
    step();
    mem(1, 0, 0);

    // reset abandons an outstanding icache read
    ic_req(1, 0, 32'h600, 0);
    step();
    ic_req(0, 0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mem(1, 1, 32'hBAD0BAD0);
    #1;
    chk("t6_ic_valid", 0, 32'(ic_v[0]), 0);
    chk("t6_dc_valid", 0, 32'(dc_v[0]), 0);
    chk("t6_idle_rdy", 0, 32'(ic_rdy[0]), 1);
    step();
    mem(1, 0, 0);
    step();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!ic_ren[k] && !ic_wen[k] &&
            $urandom_range(0, 2) == 0) begin
          ic_ren[k] = ($urandom_range(0, 3) != 0);
          ic_wen[k] = !ic_ren[k];
          ic_addr[k] = $urandom() & ~32'h3;
          ic_wdata[k] = $urandom();
        end
        if (!dc_ren[k] && !dc_wen[k] &&
            $urandom_range(0, 2) == 0) begin
          dc_ren[k] = ($urandom_range(0, 1) != 0);
          dc_wen[k] = !dc_ren[k];
          dc_addr[k] = $urandom() & ~32'h3;
          dc_wdata[k] = $urandom();
        end
        mready[k] = ($urandom_range(0, 3) != 0);
        if (owner[k] != 0) begin
          mvalid[k] = (lat[k] == 0);
          if (lat[k] > 0) lat[k]--;
        end else begin
          mvalid[k] = ($urandom_range(0, 15) == 0);
        end
        mrdata[k] = $urandom();
      end
      step();
      for (int k = 0; k < 2; k++) begin
        if (fired_ic[k]) begin
          ic_ren[k] = 0; ic_wen[k] = 0;
        end
        if (fired_dc[k]) begin
          dc_ren[k] = 0; dc_wen[k] = 0;
        end
        if (fired_rd[k]) lat[k] = $urandom_range(0, 3);
      end
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
